vpm_msg_sched: RTL and testbench

//  Sequences assertion/checker messages into the simulation error-count resource.

---
 rtl/vpm_msg_pkg.sv | 23 ++
 rtl/vpm_rr_arbiter.sv | 59 +++++
 rtl/vpm_msg_sched.sv | 180 ++++++++++++++++++
 tb/tb_vpm_msg_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpm_msg_pkg.sv
// Shared types for the checker-message scheduler.
package vpm_msg_pkg;

    typedef enum logic [1:0] {
        SEV_INFO    = 2'd0,
        SEV_WARNING = 2'd1,
        SEV_ERROR   = 2'd2,
        SEV_FATAL   = 2'd3
    } sev_t;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Fatal messages are tallied as errors; nothing else distinguishes them.
    function automatic logic sev_is_error(input sev_t sev);
        return (sev == SEV_ERROR) || (sev == SEV_FATAL);
    endfunction

endpackage

// File: rtl/vpm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves to winner+1 whenever a grant is issued.
module vpm_rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_i,
    input  logic                 advance_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q, ptr_d;

    // Two passes: requesters at/above the pointer first, then the wrapped-around ones.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        if (advance_i) begin
            for (int j = 0; j < N; j++) begin
                if (!valid_o && req_i[j] && (j >= int'(ptr_q))) begin
                    gnt_o[j] = 1'b1;
                    idx_o    = IW'(j);
                    valid_o  = 1'b1;
                end
            end
            for (int j = 0; j < N; j++) begin
                if (!valid_o && req_i[j] && (j < int'(ptr_q))) begin
                    gnt_o[j] = 1'b1;
                    idx_o    = IW'(j);
                    valid_o  = 1'b1;
                end
            end
        end
    end

    // Pointer only moves on a grant; it stays put while idle.
    always_comb begin
        ptr_d = ptr_q;
        if (valid_o) begin
            ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vpm_msg_sched.sv
// Checker-message scheduler: arbitrates checker ports, forwards accepted
// messages to the logger, keeps saturating error/warning counts and runs the
// reset-holdoff / drain / finish sequence.
//
//   state | meaning
//   HOLD  | waiting for rst_done to be stable; messages granted and dropped
//   RUN   | checks enabled; messages forwarded and counted
//   DRAIN | exit condition met; still forwarding for DRAIN_CYC cycles
//   STOP  | finish requested; no grants until reset
module vpm_msg_sched
    import vpm_msg_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int CNT_W     = 16,
    parameter int HOLDOFF   = 8,
    parameter int DRAIN_CYC = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rst_done,
    input  logic                    exit_on_warning,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [2*NREQ-1:0]       req_sev,
    output logic [NREQ-1:0]         req_ready,
    output logic                    msg_valid,
    output logic [$clog2(NREQ)-1:0] msg_src,
    output logic [1:0]              msg_sev,
    output logic [CNT_W-1:0]        errors,
    output logic [CNT_W-1:0]        warnings,
    output logic                    message_on,
    output logic                    finish_req
);

    localparam int SRC_W = $clog2(NREQ);
    localparam int HO_W  = $clog2(HOLDOFF + 1);
    localparam int DR_W  = $clog2(DRAIN_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [HO_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DR_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]  errors_q, errors_d;
    logic [CNT_W-1:0]  warnings_q, warnings_d;
    logic              msg_valid_q, msg_valid_d;
    logic [SRC_W-1:0]  msg_src_q, msg_src_d;
    logic [1:0]        msg_sev_q, msg_sev_d;

    logic              grant_en;
    logic              any_gnt;
    logic              live;
    logic              exit_now;
    logic [SRC_W-1:0]  win_idx;
    sev_t              win_sev;

    assign grant_en = (state_q != STOP);

    vpm_rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (reset),
        .req_i     (req_valid),
        .advance_i (grant_en),
        .gnt_o     (req_ready),
        .idx_o     (win_idx),
        .valid_o   (any_gnt)
    );

    assign win_sev = sev_t'(req_sev[{win_idx, 1'b0} +: 2]);
    assign live    = any_gnt && ((state_q == RUN) || (state_q == DRAIN));

    // Exit fires on the accepting edge, or later if exit_on_warning is raised
    // while warnings have already been counted.
    assign exit_now = (live && (sev_is_error(win_sev) ||
                                ((win_sev == SEV_WARNING) && exit_on_warning)))
                   || (errors_q != '0)
                   || (exit_on_warning && (warnings_q != '0));

    // Next-state logic with holdoff and drain timers.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            HOLD: begin
                if (!rst_done) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HO_W'(HOLDOFF - 1)) begin
                    hold_cnt_d = '0;
                    state_d    = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HO_W'(1);
                end
            end
            RUN: begin
                if (!rst_done) begin
                    hold_cnt_d = '0;
                    state_d    = HOLD;
                end else if (exit_now) begin
                    drain_cnt_d = DR_W'(DRAIN_CYC - 1);
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = STOP;
                end else begin
                    drain_cnt_d = drain_cnt_q - DR_W'(1);
                end
            end
            STOP: begin
                state_d = STOP;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    // Forwarded-message registers and saturating severity counters.
    always_comb begin
        msg_valid_d = live;
        msg_src_d   = msg_src_q;
        msg_sev_d   = msg_sev_q;
        errors_d    = errors_q;
        warnings_d  = warnings_q;
        if (live) begin
            msg_src_d = win_idx;
            msg_sev_d = win_sev;
            if (sev_is_error(win_sev)) begin
                if (errors_q != CNT_MAX) begin
                    errors_d = errors_q + CNT_W'(1);
                end
            end else if (win_sev == SEV_WARNING) begin
                if (warnings_q != CNT_MAX) begin
                    warnings_d = warnings_q + CNT_W'(1);
                end
            end
        end
    end

    // FSM and timer state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_valid_q <= 1'b0;
            msg_src_q   <= '0;
            msg_sev_q   <= '0;
            errors_q    <= '0;
            warnings_q  <= '0;
        end else begin
            msg_valid_q <= msg_valid_d;
            msg_src_q   <= msg_src_d;
            msg_sev_q   <= msg_sev_d;
            errors_q    <= errors_d;
            warnings_q  <= warnings_d;
        end
    end

    assign msg_valid  = msg_valid_q;
    assign msg_src    = msg_src_q;
    assign msg_sev    = msg_sev_q;
    assign errors     = errors_q;
    assign warnings   = warnings_q;
    assign message_on = (state_q == RUN) || (state_q == DRAIN);
    assign finish_req = (state_q == STOP);

endmodule

// File: tb/tb_vpm_msg_sched.sv
// Bench for vpm_msg_sched: directed sequences, a vector table and a long
// randomized run, all checked against a behavioural model. A second instance
// with 2-bit counters shares the stimulus to exercise saturation.
module tb_vpm_msg_sched;

    localparam int NREQ      = 4;
    localparam int HOLDOFF   = 8;
    localparam int DRAIN_CYC = 4;
    localparam int CW_A      = 16;
    localparam int CW_B      = 2;

    localparam int M_HOLD  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_STOP  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            rst_done;
    logic            exit_on_warning;
    logic [3:0]      req_valid;
    logic [7:0]      req_sev;

    logic [3:0]      req_ready_a, req_ready_b;
    logic            msg_valid_a, msg_valid_b;
    logic [1:0]      msg_src_a, msg_src_b;
    logic [1:0]      msg_sev_a, msg_sev_b;
    logic [CW_A-1:0] errors_a, warnings_a;
    logic [CW_B-1:0] errors_b, warnings_b;
    logic            message_on_a, message_on_b;
    logic            finish_req_a, finish_req_b;

    always #5 clk = ~clk;

    vpm_msg_sched #(.NREQ(NREQ), .CNT_W(CW_A), .HOLDOFF(HOLDOFF), .DRAIN_CYC(DRAIN_CYC)) dut_a (
        .clk(clk), .reset(reset), .rst_done(rst_done), .exit_on_warning(exit_on_warning),
        .req_valid(req_valid), .req_sev(req_sev), .req_ready(req_ready_a),
        .msg_valid(msg_valid_a), .msg_src(msg_src_a), .msg_sev(msg_sev_a),
        .errors(errors_a), .warnings(warnings_a),
        .message_on(message_on_a), .finish_req(finish_req_a));

    vpm_msg_sched #(.NREQ(NREQ), .CNT_W(CW_B), .HOLDOFF(HOLDOFF), .DRAIN_CYC(DRAIN_CYC)) dut_b (
        .clk(clk), .reset(reset), .rst_done(rst_done), .exit_on_warning(exit_on_warning),
        .req_valid(req_valid), .req_sev(req_sev), .req_ready(req_ready_b),
        .msg_valid(msg_valid_b), .msg_src(msg_src_b), .msg_sev(msg_sev_b),
        .errors(errors_b), .warnings(warnings_b),
        .message_on(message_on_b), .finish_req(finish_req_b));

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int         m_state, m_ptr, m_hold, m_drain, m_err, m_warn, m_src, m_sev;
    bit         m_mv;
    logic [3:0] m_last_gnt;
    logic [3:0] rdy_seen;

    typedef struct {
        logic       rd;
        logic       eow;
        logic [3:0] v;
        logic [7:0] s;
        logic [3:0] exp_ready;
        logic       exp_mv;
        logic [1:0] exp_src;
        logic [1:0] exp_sev;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_state = M_HOLD; m_ptr = 0; m_hold = 0; m_drain = 0;
        m_err = 0; m_warn = 0; m_src = 0; m_sev = 0; m_mv = 1'b0;
        m_last_gnt = '0;
    endtask

    function automatic int model_pick();
        if (m_state == M_STOP) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int p;
            p = (m_ptr + k) % NREQ;
            if (req_valid[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int w;
        w = model_pick();
        return (w >= 0) ? (4'b0001 << w) : 4'b0000;
    endfunction

    // One clock edge of the reference behaviour, from the inputs currently driven.
    task automatic model_step();
        int w, sev;
        bit live, ex;
        w   = model_pick();
        sev = (w >= 0) ? int'((req_sev >> (2 * w)) & 8'h03) : 0;
        m_last_gnt = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        live = (w >= 0) && (m_state == M_RUN || m_state == M_DRAIN);
        ex = (live && (sev >= 2 || (sev == 1 && exit_on_warning)))
             || (m_err > 0) || (exit_on_warning && m_warn > 0);
        m_mv = live;
        if (live) begin
            m_src = w;
            m_sev = sev;
            if (sev >= 2) m_err++;
            else if (sev == 1) m_warn++;
        end
        if (w >= 0) m_ptr = (w + 1) % NREQ;
        case (m_state)
            M_HOLD: begin
                if (rst_done) begin
                    m_hold++;
                    if (m_hold == HOLDOFF) begin
                        m_state = M_RUN;
                        m_hold  = 0;
                    end
                end else begin
                    m_hold = 0;
                end
            end
            M_RUN: begin
                if (!rst_done) begin
                    m_state = M_HOLD;
                    m_hold  = 0;
                end else if (ex) begin
                    m_state = M_DRAIN;
                    m_drain = DRAIN_CYC;
                end
            end
            M_DRAIN: begin
                m_drain--;
                if (m_drain == 0) m_state = M_STOP;
            end
            default: ;
        endcase
    endtask

    task automatic check_regs();
        bit mon;
        mon = (m_state == M_RUN) || (m_state == M_DRAIN);
        check("msg_valid",    msg_valid_a,  m_mv);
        check("msg_src",      msg_src_a,    m_src);
        check("msg_sev",      msg_sev_a,    m_sev);
        check("errors",       errors_a,     sat(m_err, CW_A));
        check("warnings",     warnings_a,   sat(m_warn, CW_A));
        check("message_on",   message_on_a, mon);
        check("finish_req",   finish_req_a, m_state == M_STOP);
        check("msg_valid_b",  msg_valid_b,  m_mv);
        check("msg_src_b",    msg_src_b,    m_src);
        check("msg_sev_b",    msg_sev_b,    m_sev);
        check("errors_b",     errors_b,     sat(m_err, CW_B));
        check("warnings_b",   warnings_b,   sat(m_warn, CW_B));
        check("message_on_b", message_on_b, mon);
        check("finish_req_b", finish_req_b, m_state == M_STOP);
    endtask

    // Drive one cycle of inputs, check the grant before the edge and all
    // registered outputs just after it.
    task automatic step(input logic rd, input logic eow, input logic [3:0] v, input logic [7:0] s);
        rst_done = rd; exit_on_warning = eow; req_valid = v; req_sev = s;
        #1;
        rdy_seen = req_ready_a;
        check("req_ready",   req_ready_a, model_ready());
        check("req_ready_b", req_ready_b, model_ready());
        @(posedge clk);
        model_step();
        #1;
        check_regs();
    endtask

    // Asynchronous reset applied between edges; outputs must clear before any edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check("rst_message_on", message_on_a, 0);
        check("rst_finish_req", finish_req_a, 0);
        check("rst_errors",     errors_a,     0);
        check("rst_warnings",   warnings_a,   0);
        check("rst_warnings_b", warnings_b,   0);
        check("rst_msg_valid",  msg_valid_a,  0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_up();
        for (int k = 0; k < HOLDOFF; k++) step(1'b1, 1'b0, 4'b0000, 8'h00);
        check("run_up_message_on", message_on_a, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pend_v;
        logic [7:0] pend_s;

        //          rd    eow   valid    sev    ready    mv    src    sev
        tbl[0] = '{1'b1, 1'b0, 4'b1111, 8'h00, 4'b0001, 1'b1, 2'd0, 2'd0};
        tbl[1] = '{1'b1, 1'b0, 4'b1111, 8'h00, 4'b0010, 1'b1, 2'd1, 2'd0};
        tbl[2] = '{1'b1, 1'b0, 4'b1111, 8'h00, 4'b0100, 1'b1, 2'd2, 2'd0};
        tbl[3] = '{1'b1, 1'b0, 4'b1111, 8'h00, 4'b1000, 1'b1, 2'd3, 2'd0};
        tbl[4] = '{1'b1, 1'b0, 4'b1111, 8'h00, 4'b0001, 1'b1, 2'd0, 2'd0};
        tbl[5] = '{1'b1, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0, 2'd0, 2'd0};

        reset = 1'b1; rst_done = 1'b0; exit_on_warning = 1'b0;
        req_valid = '0; req_sev = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_message_on", message_on_a, 0);
        check("reset_finish_req", finish_req_a, 0);
        check("reset_errors",     errors_a,     0);
        check("reset_warnings",   warnings_a,   0);
        check("reset_msg_valid",  msg_valid_a,  0);
        reset = 1'b0;

        // holdoff: message_on rises exactly HOLDOFF edges after rst_done; warning in HOLD dropped
        for (int k = 1; k <= HOLDOFF; k++) begin
            step(1'b1, 1'b0, (k == 1) ? 4'b1000 : 4'b0000, (k == 1) ? 8'h40 : 8'h00);
            if (k == 1) check("t1_hold_grant", rdy_seen, 4'b1000);
            check("t1_message_on", message_on_a, (k == HOLDOFF));
            check("t1_warn_dropped", warnings_a, 0);
        end

        // round robin over all-valid info requests
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].rd, tbl[i].eow, tbl[i].v, tbl[i].s);
            check("t2_ready",   rdy_seen,    tbl[i].exp_ready);
            check("t2_valid",   msg_valid_a, tbl[i].exp_mv);
            check("t2_src",     msg_src_a,   tbl[i].exp_src);
            check("t2_sev",     msg_sev_a,   tbl[i].exp_sev);
        end

        // warning without exit, then late exit_on_warning
        step(1'b1, 1'b0, 4'b0100, 8'h10);
        check("t3_ready",    rdy_seen,   4'b0100);
        check("t3_src",      msg_src_a,  2);
        check("t3_sev",      msg_sev_a,  1);
        check("t3_warnings", warnings_a, 1);
        repeat (6) step(1'b1, 1'b0, 4'b0000, 8'h00);
        check("t3_still_run", finish_req_a, 0);
        for (int k = 1; k <= DRAIN_CYC + 1; k++) begin
            step(1'b1, 1'b1, 4'b0000, 8'h00);
            check("t3_finish", finish_req_a, (k == DRAIN_CYC + 1));
        end
        step(1'b1, 1'b1, 4'b1111, 8'h00);
        check("t3_stop_ready", rdy_seen,    4'b0000);
        check("t3_stop_valid", msg_valid_a, 0);
        do_reset();

        // error drains, finish after DRAIN_CYC, no grants in STOP
        run_up();
        step(1'b1, 1'b0, 4'b0010, 8'h08);
        check("t4_ready",  rdy_seen, 4'b0010);
        check("t4_errors", errors_a, 1);
        check("t4_sev",    msg_sev_a, 2);
        for (int k = 1; k <= DRAIN_CYC; k++) begin
            step(1'b1, 1'b0, 4'b0001, 8'h00);
            check("t4_finish",     finish_req_a, (k == DRAIN_CYC));
            check("t4_message_on", message_on_a, (k < DRAIN_CYC));
        end
        step(1'b1, 1'b0, 4'b1111, 8'h00);
        check("t4_stop_ready", rdy_seen, 4'b0000);
        check("t4_errors_end", errors_a, 1);
        do_reset();

        // saturation of the 2-bit instance
        run_up();
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0, 4'b0100, 8'h10);
            check("t5_warnings_a", warnings_a, k);
            check("t5_warnings_b", warnings_b, (k > 3) ? 3 : k);
        end

        // rst_done drop returns to HOLD with counts held; count-based exit afterwards
        step(1'b0, 1'b0, 4'b0000, 8'h00);
        check("t6_message_on", message_on_a, 0);
        check("t6_warnings_a", warnings_a, 5);
        check("t6_warnings_b", warnings_b, 3);
        step(1'b0, 1'b0, 4'b0010, 8'h04);
        check("t6_hold_ready", rdy_seen,    4'b0010);
        check("t6_hold_valid", msg_valid_a, 0);
        check("t6_hold_count", warnings_a,  5);
        run_up();
        for (int k = 1; k <= DRAIN_CYC + 1; k++) begin
            step(1'b1, 1'b1, 4'b0000, 8'h00);
            check("t6_finish", finish_req_a, (k == DRAIN_CYC + 1));
        end
        do_reset();

        // reset while draining
        run_up();
        step(1'b1, 1'b0, 4'b0001, 8'h03);
        repeat (2) step(1'b1, 1'b0, 4'b0000, 8'h00);
        check("t7_in_drain", message_on_a, 1);
        do_reset();

        // randomized traffic; requesters hold valid/sev until granted
        pend_v = '0;
        pend_s = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NREQ; p++) begin
                if (!pend_v[p] && ($urandom_range(0, 2) == 0)) begin
                    int r;
                    r = $urandom_range(0, 15);
                    pend_v[p] = 1'b1;
                    pend_s[2*p +: 2] = (r < 11) ? 2'd0 : (r < 14) ? 2'd1 : (r == 14) ? 2'd2 : 2'd3;
                end
            end
            step($urandom_range(0, 31) != 0, $urandom_range(0, 63) == 0, pend_v, pend_s);
            pend_v = pend_v & ~m_last_gnt;
            if ((m_state == M_STOP && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) begin
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
